x9_instr_encoder: RTL and testbench

- Inverse of the X9 control decoder. Accepts symbolic instruction requests (5-bit opcode plus 4-bit operand) over a valid/ready handshake.
- Packs each request into a 9-bit X9 machine word as {opcode[8:4], operand[3:0]}. Buffers words in a small FIFO.
- Streams words into instruction memory through a write port with an auto-incrementing address.
- Used as the program loader that fills instruction memory before the core is released from reset.

---
 rtl/x9_pkg.sv | 41 ++++
 rtl/x9_sync_fifo.sv | 47 ++++
 rtl/x9_instr_encoder.sv | 153 +++++++++++++++
 tb/tb_x9_instr_encoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/x9_pkg.sv
// x9_pkg: definitions shared by the X9 instruction encoder and the control
// decoder.
//   - INSTR_W: width of an X9 machine word ({opcode[8:4], operand[3:0]}).
//   - OP_*: opcode values for the 5-bit major field.
//   - enc_state_e: states of the program-loader encoder.
//   - is_legal_op(): returns 1 for opcodes that the decoder implements.
package x9_pkg;

  localparam int INSTR_W = 9;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_LB   = 5'b00011;
  localparam logic [4:0] OP_SB   = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;
  localparam logic [4:0] OP_BEQ  = 5'b01010;
  localparam logic [4:0] OP_BNE  = 5'b01011;
  localparam logic [4:0] OP_JMP  = 5'b01100;
  localparam logic [4:0] OP_RAND = 5'b01101;
  localparam logic [4:0] OP_ROR  = 5'b01110;
  localparam logic [4:0] OP_RXOR = 5'b01111;
  localparam logic [4:0] OP_MOVR = 5'b10000;
  localparam logic [4:0] OP_MOVI = 5'b11000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } enc_state_e;

  // The whole 0xxxx range is ALU/memory/branch; only two codes exist above it.
  function automatic logic is_legal_op(input logic [4:0] op);
    return (op[4] == 1'b0) || (op == OP_MOVR) || (op == OP_MOVI);
  endfunction

endpackage

// File: rtl/x9_sync_fifo.sv
// x9_sync_fifo: single-clock FIFO holding encoded X9 words.
// Ports:
//   clk, rst   - clock and synchronous active-high reset (pointers only)
//   push,wdata - write request and word; ignored when full
//   pop, rdata - read request; rdata always shows the head word
//   full,empty - occupancy flags
// DEPTH must be a power of two and at least 2.
module x9_sync_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [PW:0]       wp;
  logic [PW:0]       rp;

  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign rdata = mem[rp[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)  wp <= wp + 1'b1;
      if (pop  && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/x9_instr_encoder.sv
// x9_instr_encoder: program loader that packs symbolic requests
// {opcode, operand} into 9-bit X9 words, buffers them and streams them into
// instruction memory at consecutive addresses starting at StartAddr.
// Ports:
//   Clk, Reset         - clock, synchronous active-high reset
//   Start, StartAddr   - begin a session (only honoured in IDLE)
//   InValid/InReady    - request handshake; InOp, InArg, InLast carry it
//   WrEn/WrAddr/WrData - registered instruction-memory write port
//   Busy, Done, Err    - session status (Err is sticky until Start/Reset)
//   Count              - words written in the current session
// Optional build macro: X9_ENC_LEGAL_CHECK_EN drops requests carrying
// undefined opcodes and flags Err.
module x9_instr_encoder
  import x9_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int OPW   = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [AW-1:0]      StartAddr,
  input  logic               InValid,
  input  logic [OPW-1:0]     InOp,
  input  logic [3:0]         InArg,
  input  logic               InLast,
  output logic               InReady,
  output logic               WrEn,
  output logic [AW-1:0]      WrAddr,
  output logic [INSTR_W-1:0] WrData,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [AW:0]        Count
);

  enc_state_e         state;
  enc_state_e         state_nxt;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      acc_ptr;
  logic               space_exhausted;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] word_p0;
  logic [INSTR_W-1:0] head_p1;
  logic               accept;
  logic               op_ok;
  logic               push;
  logic               pop;
  logic               exhaust_err;
  logic               drain_done;

  assign word_p0 = {InOp, InArg};
  assign accept  = InValid && InReady;

`ifdef X9_ENC_LEGAL_CHECK_EN
  assign op_ok = is_legal_op(InOp);
`else
  assign op_ok = 1'b1;
`endif

  assign push = accept && op_ok;
  // Words only ever live in the FIFO during a session, so popping is gated by
  // state purely to make reset-to-IDLE stop the write stream immediately.
  assign pop  = !fifo_empty && (state != IDLE);

  // Sender keeps pushing after the last address was consumed: abandon input.
  assign exhaust_err = (state == RUN) && space_exhausted && InValid;
  // WrEn high means the final word is still on the write port this cycle.
  assign drain_done  = (state == DRAIN) && fifo_empty && !WrEn;

  // ---- stage p0 -> p1: request enters the buffer ----
  x9_sync_fifo #(
    .DATA_W (INSTR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (push),
    .wdata (word_p0),
    .pop   (pop),
    .rdata (head_p1),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if ((accept && InLast) || exhaust_err) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    InReady = (state == RUN) && !fifo_full && !space_exhausted;
    Busy    = (state != IDLE);
    Done    = drain_done;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr          <= '0;
      acc_ptr         <= '0;
      space_exhausted <= 1'b0;
      Err             <= 1'b0;
      Count           <= '0;
    end else begin
      if ((state == IDLE) && Start) begin
        wr_ptr          <= StartAddr;
        acc_ptr         <= StartAddr;
        space_exhausted <= 1'b0;
        Err             <= 1'b0;
        Count           <= '0;
      end
      if (push) begin
        acc_ptr <= acc_ptr + 1'b1;
        // The word just accepted targets the top address: no room remains.
        if (acc_ptr == '1) space_exhausted <= 1'b1;
      end
      if (accept && !op_ok) Err <= 1'b1;
      if (exhaust_err)      Err <= 1'b1;
      if (pop) begin
        wr_ptr <= wr_ptr + 1'b1;
        Count  <= Count + 1'b1;
      end
    end
  end

  // ---- stage p1 -> p2: head word presented on the memory write port ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      WrEn   <= 1'b0;
      WrAddr <= '0;
      WrData <= '0;
    end else begin
      WrEn <= pop;
      if (pop) begin
        WrAddr <= wr_ptr;
        WrData <= head_p1;
      end
    end
  end

endmodule

// File: tb/tb_x9_instr_encoder.sv
// tb_x9_instr_encoder: directed bench for the X9 program loader.
// The DUT is built with DEPTH=2 so the streaming cases also exercise the
// smallest buffer. A monitor logs every memory write (address, data, cycle)
// and Done pulses; each scenario compares that log with hand-computed words.
module tb_x9_instr_encoder;
  import x9_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] StartAddr = '0;
  logic       InValid = 1'b0;
  logic [4:0] InOp = '0;
  logic [3:0] InArg = '0;
  logic       InLast = 1'b0;
  logic       InReady;
  logic       WrEn;
  logic [7:0] WrAddr;
  logic [8:0] WrData;
  logic       Busy;
  logic       Done;
  logic       Err;
  logic [8:0] Count;

  x9_instr_encoder #(.AW(8), .DEPTH(2), .OPW(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .InValid(InValid), .InOp(InOp), .InArg(InArg), .InLast(InLast),
    .InReady(InReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Busy(Busy), .Done(Done), .Err(Err), .Count(Count)
  );

  always #5 Clk = ~Clk;

  int         cyc = 0;
  int         done_cnt = 0;
  logic [7:0] wa[$];
  logic [8:0] wd[$];
  int         wc[$];
  int         n_chk = 0;
  int         n_pass = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (WrEn) begin
      wa.push_back(WrAddr);
      wd.push_back(WrData);
      wc.push_back(cyc);
    end
    if (Done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // All driving and sampling happens just after the falling edge.
  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [3:0] arg, input logic last,
                      output bit acc);
    InValid = 1'b1; InOp = op; InArg = arg; InLast = last; acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (InReady) begin
        acc = 1'b1;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic idle_in();
    InValid = 1'b0; InLast = 1'b0;
  endtask

  task automatic start_at(input logic [7:0] addr);
    Start = 1'b1; StartAddr = addr;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && Busy; i++) tick();
    chk(tag, Busy, 1'b0);
  endtask

  logic [8:0] exp_d[6];
  int         b0;
  int         d0;
  bit         acc;

  initial begin
    // ---- reset values ----
    repeat (3) tick();
    chk("rst_inready", InReady, 0);
    chk("rst_wren", WrEn, 0);
    chk("rst_wraddr", WrAddr, 0);
    chk("rst_wrdata", WrData, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_err", Err, 0);
    chk("rst_count", Count, 0);
    Reset = 1'b0;
    tick();

    // ---- single word: add r3 at 0x10, two-cycle latency ----
    start_at(8'h10);
    b0 = wa.size(); d0 = done_cnt;
    chk("t1_busy", Busy, 1);
    send(OP_ADD, 4'd3, 1'b1, acc);
    chk("t1_acc", acc, 1);
    chk("t1_wren_lat1", WrEn, 0);
    idle_in();
    tick();
    chk("t1_wren_lat2", WrEn, 1);
    chk("t1_addr", WrAddr, 8'h10);
    chk("t1_data", WrData, 9'h003);
    wait_idle("t1_idle");
    chk("t1_nwr", wa.size() - b0, 1);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_count", Count, 1);
    chk("t1_err", Err, 0);

    // ---- back-to-back stream: movi 5, movr 2, lb 7, sb 1 ----
    start_at(8'h30);
    b0 = wa.size(); d0 = done_cnt;
    send(OP_MOVI, 4'd5, 1'b0, acc);
    send(OP_MOVR, 4'd2, 1'b0, acc);
    send(OP_LB,   4'd7, 1'b0, acc);
    send(OP_SB,   4'd1, 1'b1, acc);
    idle_in();
    wait_idle("t2_idle");
    exp_d[0] = 9'h185; exp_d[1] = 9'h102; exp_d[2] = 9'h037; exp_d[3] = 9'h041;
    chk("t2_nwr", wa.size() - b0, 4);
    if (wa.size() - b0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("t2_addr%0d", k), wa[b0+k], 8'h30 + 8'(k));
        chk($sformatf("t2_data%0d", k), wd[b0+k], exp_d[k]);
        chk($sformatf("t2_gap%0d", k), wc[b0+k] - wc[b0], k);
      end
    end
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_count", Count, 4);

    // ---- six-word stream through the 2-deep FIFO; stray Start ignored ----
    start_at(8'h20);
    b0 = wa.size(); d0 = done_cnt;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin Start = 1'b1; StartAddr = 8'h80; end
      send(5'(k), 4'(k + 8), (k == 5), acc);
      Start = 1'b0;
      chk($sformatf("t3_acc%0d", k), acc, 1);
    end
    idle_in();
    wait_idle("t3_idle");
    chk("t3_nwr", wa.size() - b0, 6);
    if (wa.size() - b0 == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("t3_addr%0d", k), wa[b0+k], 8'h20 + 8'(k));
        chk($sformatf("t3_data%0d", k), wd[b0+k], {5'(k), 4'(k + 8)});
        chk($sformatf("t3_gap%0d", k), wc[b0+k] - wc[b0], k);
      end
    end
    chk("t3_done", done_cnt - d0, 1);
    chk("t3_count", Count, 6);

    // ---- address space end at 0xFE: third request refused ----
    start_at(8'hFE);
    b0 = wa.size(); d0 = done_cnt;
    send(OP_ADD, 4'd1, 1'b0, acc);
    chk("t4_acc0", acc, 1);
    send(OP_ADD, 4'd2, 1'b0, acc);
    chk("t4_acc1", acc, 1);
    send(OP_ADD, 4'd3, 1'b0, acc);
    chk("t4_acc2", acc, 0);
    idle_in();
    wait_idle("t4_idle");
    chk("t4_nwr", wa.size() - b0, 2);
    if (wa.size() - b0 == 2) begin
      chk("t4_addr0", wa[b0], 8'hFE);
      chk("t4_data0", wd[b0], 9'h001);
      chk("t4_addr1", wa[b0+1], 8'hFF);
      chk("t4_data1", wd[b0+1], 9'h002);
    end
    chk("t4_err", Err, 1);
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_count", Count, 2);

    // ---- undefined opcode 10101 between two adds ----
    start_at(8'h40);
    chk("t5_err_clr", Err, 0);
    b0 = wa.size(); d0 = done_cnt;
    send(OP_ADD, 4'd1, 1'b0, acc);
    send(5'b10101, 4'd0, 1'b0, acc);
    chk("t5_acc_bad", acc, 1);
    send(OP_ADD, 4'd2, 1'b1, acc);
    idle_in();
    wait_idle("t5_idle");
`ifdef X9_ENC_LEGAL_CHECK_EN
    chk("t5_nwr", wa.size() - b0, 2);
    if (wa.size() - b0 == 2) begin
      chk("t5_addr0", wa[b0], 8'h40);
      chk("t5_data0", wd[b0], 9'h001);
      chk("t5_addr1", wa[b0+1], 8'h41);
      chk("t5_data1", wd[b0+1], 9'h002);
    end
    chk("t5_err", Err, 1);
`else
    chk("t5_nwr", wa.size() - b0, 3);
    if (wa.size() - b0 == 3) begin
      chk("t5_addr1", wa[b0+1], 8'h41);
      chk("t5_data0", wd[b0], 9'h001);
      chk("t5_data1", wd[b0+1], 9'h150);
      chk("t5_addr2", wa[b0+2], 8'h42);
      chk("t5_data2", wd[b0+2], 9'h002);
    end
    chk("t5_err", Err, 0);
`endif
    chk("t5_done", done_cnt - d0, 1);

    // ---- reset one cycle after the second accept of a 4-word burst ----
    start_at(8'h50);
    send(OP_SUB, 4'd1, 1'b0, acc);
    send(OP_SUB, 4'd2, 1'b0, acc);
    InOp = OP_SUB; InArg = 4'd3;
    tick();
    Reset = 1'b1;
    idle_in();
    tick();
    chk("t6_inready", InReady, 0);
    chk("t6_wren", WrEn, 0);
    chk("t6_wraddr", WrAddr, 0);
    chk("t6_wrdata", WrData, 0);
    chk("t6_busy", Busy, 0);
    chk("t6_done", Done, 0);
    chk("t6_err", Err, 0);
    chk("t6_count", Count, 0);
    Reset = 1'b0;
    b0 = wa.size();
    repeat (10) tick();
    chk("t6_no_wr", wa.size() - b0, 0);
    chk("t6_count_after", Count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
